// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core hazard logic:
//   - operand-forward select encodings (FWD_REGFILE / FWD_MEM / FWD_WB)
//   - hazard FSM state enum (RUN, WAIT)
//   - scoreboard entry struct {valid, addr, load} and its width
//   - entry_match(): true when a valid in-flight write targets a source read
// Optional feature macro used by the consumers of this package:
//   HAZARD_FORWARD_EN
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_MEM     = 2'b01;
   localparam logic [1:0] FWD_WB      = 2'b10;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } hazard_state_e;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] addr;
      logic              load;
   } sb_entry_t;

   localparam int SB_ENTRY_W = $bits(sb_entry_t);

   // $0 is hard-wired to zero, so a read of it never depends on anything.
   function automatic logic entry_match(input sb_entry_t e,
                                        input logic uses,
                                        input logic [REG_AW-1:0] addr);
      return uses && (addr != '0) && e.valid && (e.addr == addr);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Three-entry shift register (EX, MEM, WB) of register writes in flight, and
// per-source match vectors for the instruction currently in ID.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   advance_i           shift the pipeline (0 = hold every entry)
//   new_valid_i         instruction entering EX writes a register (0 = bubble)
//   new_addr_i          destination of the instruction entering EX
//   new_load_i          instruction entering EX is a load
//   uses_s_i/s_addr_i   rs read of the ID instruction
//   uses_t_i/t_addr_i   rt read of the ID instruction
//   s_match_o/t_match_o match vectors, bit0 = EX, bit1 = MEM, bit2 = WB
//   mem_load_o          the MEM entry holds a load
// -----------------------------------------------------------------------------
module hazard_scoreboard
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance_i,
   input  logic              new_valid_i,
   input  logic [REG_AW-1:0] new_addr_i,
   input  logic              new_load_i,
   input  logic              uses_s_i,
   input  logic [REG_AW-1:0] s_addr_i,
   input  logic              uses_t_i,
   input  logic [REG_AW-1:0] t_addr_i,
   output logic [2:0]        s_match_o,
   output logic [2:0]        t_match_o,
   output logic              mem_load_o
);

   sb_entry_t ex_q, mem_q, wb_q;
   sb_entry_t ex_d;

   // A write to $0 is discarded, so it never enters as a valid entry.
   always_comb begin
      ex_d       = '0;
      ex_d.valid = new_valid_i && (new_addr_i != '0);
      ex_d.addr  = new_addr_i;
      ex_d.load  = new_load_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (advance_i) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
      end
   end

   assign s_match_o = {entry_match(wb_q,  uses_s_i, s_addr_i),
                       entry_match(mem_q, uses_s_i, s_addr_i),
                       entry_match(ex_q,  uses_s_i, s_addr_i)};
   assign t_match_o = {entry_match(wb_q,  uses_t_i, t_addr_i),
                       entry_match(mem_q, uses_t_i, t_addr_i),
                       entry_match(ex_q,  uses_t_i, t_addr_i)};
   assign mem_load_o = mem_q.load;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for the five-stage MIPS core. Decides stall,
// bubble, freeze, flush and operand-forward controls in the same cycle from
// the ID fields and the in-flight write scoreboard.
// Optional feature: `define HAZARD_FORWARD_EN enables MEM/WB forwarding;
// without it the forward selects stay at the register file and any EX or MEM
// match stalls (the register file writes through, so WB needs nothing).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reg_s_addr/uses_s          rs read of the ID instruction
//   reg_t_addr/uses_t          rt read of the ID instruction
//   reg_d_we/reg_d_addr        destination write of the ID instruction
//   reg_d_data_sel             ID instruction is a load
//   jump                       taken branch/jump resolved in ID
//   mem_req/mem_ready          data-memory access and completion in MEM
//   stall_if/stall_id          hold PC / IF/ID register
//   bubble_ex                  load a NOP into ID/EX
//   freeze                     hold ID/EX, EX/MEM, MEM/WB
//   flush_id                   replace IF/ID with a NOP
//   fwd_s_sel/fwd_t_sel        operand source for rs/rt
// Handshake: a memory access that is requested (mem_req) but not completed
// (mem_ready low) freezes the back end that cycle; the access completes on
// the first cycle mem_ready is high, with no freeze in that cycle.
// -----------------------------------------------------------------------------
module hazard_unit
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] reg_s_addr,
   input  logic [REG_AW-1:0] reg_t_addr,
   input  logic              uses_s,
   input  logic              uses_t,
   input  logic              reg_d_we,
   input  logic [REG_AW-1:0] reg_d_addr,
   input  logic              reg_d_data_sel,
   input  logic              jump,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_id,
   output logic              bubble_ex,
   output logic              freeze,
   output logic              flush_id,
   output logic [1:0]        fwd_s_sel,
   output logic [1:0]        fwd_t_sel
);

   hazard_state_e state_q;
   logic [2:0]    s_match, t_match;
   logic          mem_load;
   logic          freeze_c, hazard_c;
   logic          stall_s, stall_t;

   assign freeze_c = mem_req & ~mem_ready;

   // The state only tracks the memory wait; freeze itself is decided from the
   // same-cycle handshake so the first wait cycle is covered too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         case (state_q)
            RUN:     if (freeze_c)  state_q <= WAIT;
            WAIT:    if (mem_ready) state_q <= RUN;
            default:                state_q <= RUN;
         endcase
      end
   end

   hazard_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance_i  (~freeze_c),
      .new_valid_i(reg_d_we & ~hazard_c),
      .new_addr_i (reg_d_addr),
      .new_load_i (reg_d_data_sel),
      .uses_s_i   (uses_s),
      .s_addr_i   (reg_s_addr),
      .uses_t_i   (uses_t),
      .t_addr_i   (reg_t_addr),
      .s_match_o  (s_match),
      .t_match_o  (t_match),
      .mem_load_o (mem_load)
   );

`ifdef HAZARD_FORWARD_EN
   // The youngest matching producer decides: EX is never forwardable, a load
   // in MEM has no data yet, otherwise take MEM before WB.
   assign stall_s   = s_match[0] | (s_match[1] & mem_load);
   assign stall_t   = t_match[0] | (t_match[1] & mem_load);
   assign fwd_s_sel = s_match[0] ? FWD_REGFILE :
                      s_match[1] ? (mem_load ? FWD_REGFILE : FWD_MEM) :
                      s_match[2] ? FWD_WB : FWD_REGFILE;
   assign fwd_t_sel = t_match[0] ? FWD_REGFILE :
                      t_match[1] ? (mem_load ? FWD_REGFILE : FWD_MEM) :
                      t_match[2] ? FWD_WB : FWD_REGFILE;
`else
   logic unused_nofwd;
   assign unused_nofwd = &{1'b0, s_match[2], t_match[2], mem_load, state_q};
   assign stall_s   = s_match[0] | s_match[1];
   assign stall_t   = t_match[0] | t_match[1];
   assign fwd_s_sel = FWD_REGFILE;
   assign fwd_t_sel = FWD_REGFILE;
`endif

   assign hazard_c  = stall_s | stall_t;

   // Freeze wins over a data hazard: hold everything, insert no bubble.
   assign freeze    = freeze_c;
   assign stall_if  = freeze_c | hazard_c;
   assign stall_id  = freeze_c | hazard_c;
   assign bubble_ex = ~freeze_c & hazard_c;
   assign flush_id  = jump & ~stall_id & ~freeze_c;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] reg_s_addr = '0, reg_t_addr = '0, reg_d_addr = '0;
   logic       uses_s = 0, uses_t = 0, reg_d_we = 0, reg_d_data_sel = 0;
   logic       jump = 0, mem_req = 0, mem_ready = 0;
   logic       stall_if, stall_id, bubble_ex, freeze, flush_id;
   logic [1:0] fwd_s_sel, fwd_t_sel;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Reference: list of the last three issued instructions' writes, youngest
   // first (age 0 = one slot ahead of ID, age 2 = three slots ahead).
   logic       h_we[3];
   logic [4:0] h_addr[3];
   logic       h_ld[3];

   hazard_unit dut (
      .clk(clk), .rst_n(rst_n),
      .reg_s_addr(reg_s_addr), .reg_t_addr(reg_t_addr),
      .uses_s(uses_s), .uses_t(uses_t),
      .reg_d_we(reg_d_we), .reg_d_addr(reg_d_addr), .reg_d_data_sel(reg_d_data_sel),
      .jump(jump), .mem_req(mem_req), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .freeze(freeze), .flush_id(flush_id),
      .fwd_s_sel(fwd_s_sel), .fwd_t_sel(fwd_t_sel)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         h_we[i] = 0; h_addr[i] = '0; h_ld[i] = 0;
      end
   endtask

   // Dependency of one source operand on the in-flight writes.
   task automatic src_eval(input logic use_r, input logic [4:0] a,
                           output logic stl, output logic [1:0] fw);
      bit found;
      stl = 0; fw = 2'b00; found = 0;
      if (use_r && a != 0) begin
         for (int age = 0; age < 3; age++) begin
            if (!found && h_we[age] && h_addr[age] == a) begin
               found = 1;
`ifdef HAZARD_FORWARD_EN
               if (age == 0) stl = 1;
               else if (age == 1) begin
                  if (h_ld[age]) stl = 1; else fw = 2'b01;
               end else fw = 2'b10;
`else
               if (age < 2) stl = 1;
`endif
            end
         end
      end
   endtask

   task automatic model_outputs(output logic [8:0] ev, output logic haz, output logic frz);
      logic ss, st;
      logic [1:0] fs, ft;
      logic stl;
      src_eval(uses_s, reg_s_addr, ss, fs);
      src_eval(uses_t, reg_t_addr, st, ft);
      haz = ss | st;
      frz = mem_req & ~mem_ready;
      stl = haz | frz;
      ev = {stl, stl, haz & ~frz, frz, jump & ~stl, fs, ft};
   endtask

   task automatic check_vec(input string tag, input logic [8:0] exp_v);
      logic [8:0] obs;
      obs = {stall_if, stall_id, bubble_ex, freeze, flush_id, fwd_s_sel, fwd_t_sel};
      checks++;
      assert (obs === exp_v) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   // One ID cycle: drive after the edge, compare mid-cycle, then advance the
   // reference exactly as the pipeline will at the next edge.
   task automatic issue(input string tag,
                        input logic us, input logic [4:0] sa,
                        input logic ut, input logic [4:0] ta,
                        input logic we, input logic [4:0] da, input logic ld,
                        input logic jmp, input logic mreq, input logic mrdy);
      logic [8:0] ev;
      logic haz, frz;
      @(posedge clk);
      #1;
      uses_s = us; reg_s_addr = sa; uses_t = ut; reg_t_addr = ta;
      reg_d_we = we; reg_d_addr = da; reg_d_data_sel = ld;
      jump = jmp; mem_req = mreq; mem_ready = mrdy;
      #3;
      model_outputs(ev, haz, frz);
      check_vec(tag, ev);
      if (!frz) begin
         h_we[2] = h_we[1]; h_addr[2] = h_addr[1]; h_ld[2] = h_ld[1];
         h_we[1] = h_we[0]; h_addr[1] = h_addr[0]; h_ld[1] = h_ld[0];
         h_we[0] = we & ~haz & (da != 0); h_addr[0] = da; h_ld[0] = ld;
      end
   endtask

   task automatic nop(input string tag);
      issue(tag, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
   endtask

   initial begin
      model_clear();
      #12;
      check_vec("reset_outputs", 9'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // lw $2 ; add $3,$2,$4 held in ID until it issues
      issue("lw_2",        1, 5'd1, 0, 5'd0, 1, 5'd2, 1, 0, 0, 0);
      issue("lu_stall1",   1, 5'd2, 1, 5'd4, 1, 5'd3, 0, 0, 0, 0);
      issue("lu_stall2",   1, 5'd2, 1, 5'd4, 1, 5'd3, 0, 0, 0, 0);
      issue("lu_go",       1, 5'd2, 1, 5'd4, 1, 5'd3, 0, 0, 0, 0);
      nop("lu_drain1"); nop("lu_drain2"); nop("lu_drain3");

      // add $5,$1,$1 ; beq $5,$0 with jump resolved in ID
      issue("add_5",       1, 5'd1, 1, 5'd1, 1, 5'd5, 0, 0, 0, 0);
      issue("beq_stall",   1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
      issue("beq_go",      1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
      nop("beq_drain1"); nop("beq_drain2"); nop("beq_drain3");

      // write to $0 then read $0
      issue("wr_zero",     0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 0);
      issue("rd_zero",     1, 5'd0, 1, 5'd0, 1, 5'd6, 0, 0, 0, 0);
      nop("z_drain1"); nop("z_drain2"); nop("z_drain3");

      // memory wait of 3 cycles with a load-use pending
      issue("lw_7",        0, 5'd0, 0, 5'd0, 1, 5'd7, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         issue("freeze_lu", 1, 5'd7, 0, 5'd0, 1, 5'd8, 0, 1, 1, 0);
      issue("mem_done",    1, 5'd7, 0, 5'd0, 1, 5'd8, 0, 0, 1, 1);
      issue("lu_resume",   1, 5'd7, 0, 5'd0, 1, 5'd8, 0, 0, 0, 0);
      issue("lu_resume2",  1, 5'd7, 0, 5'd0, 1, 5'd8, 0, 0, 0, 0);
      nop("f_drain1"); nop("f_drain2"); nop("f_drain3");

      // two back-to-back ALU producers, rt operand
      issue("add_2",       0, 5'd0, 0, 5'd0, 1, 5'd2, 0, 0, 0, 0);
      issue("add_3_2",     1, 5'd9, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0);
      issue("add_3_2b",    1, 5'd9, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0);
      issue("add_3_2c",    1, 5'd9, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0);

      // reset pulsed in the middle of a memory wait, $2 write pending
      issue("lw_2b",       0, 5'd0, 0, 5'd0, 1, 5'd2, 1, 0, 0, 0);
      issue("wait_a",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      mem_req = 0; mem_ready = 0; jump = 0; reg_d_we = 0;
      uses_s = 1; reg_s_addr = 5'd2; uses_t = 0;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_vec("rst_async", 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      issue("post_rst_rd2", 1, 5'd2, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);

      // randomized traffic over a small register window to force collisions
      for (int n = 0; n < 400; n++) begin
         logic mreq;
         mreq = ($urandom_range(0, 3) == 0);
         issue("random",
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               mreq, mreq & ($urandom_range(0, 2) != 0));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. Tracks register writes in flight in EX, MEM and WB with a small scoreboard. Uses the decode stage's source and destination fields to drive stall, bubble, flush and operand-forward controls. Sits beside the decode stage and gates the IF/ID and ID/EX pipeline registers, including during data-memory wait states.

## Interface
- No parameters; register-address width is fixed at 5.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- reg_s_addr  in  5  rs field of instruction in ID
- reg_t_addr  in  5  rt field of instruction in ID
- uses_s  in  1  ID instruction reads rs (includes branches)
- uses_t  in  1  ID instruction reads rt (R-type, branches, stores)
- reg_d_we  in  1  ID instruction writes a register
- reg_d_addr  in  5  ID destination register (after rd/rt select)
- reg_d_data_sel  in  1  1 = ID instruction is a load (result from memory)
- jump  in  1  taken branch/jump resolved in ID
- mem_req  in  1  MEM stage is accessing data memory this cycle
- mem_ready  in  1  data memory completes the access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register (ir, pc)
- bubble_ex  out  1  load a NOP into ID/EX (we/mem_we cleared)
- freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- flush_id  out  1  replace IF/ID contents with NOP
- fwd_s_sel  out  2  rs operand source for ID: 00 regfile, 01 MEM ALU result, 10 WB result
- fwd_t_sel  out  2  rt operand source, same encoding

## Operation
- Scoreboard: three entries EX, MEM, WB, each {valid, addr[4:0], load}. Entry is valid only when we=1 and addr≠0.
- Advance (state RUN, no freeze): WB←MEM, MEM←EX, EX←{reg_d_we & ~hazard, reg_d_addr, reg_d_data_sel}. A bubble enters as valid=0.
- Hazard match for source X: uses_X & addr_X≠0 & entry.valid & entry.addr==addr_X.
- With forwarding:
  - Stall when EX matches, since its result is not yet available for the compare in ID.
  - Stall when MEM matches with load=1.
  - MEM match with load=0 gives fwd=01.
  - WB match gives fwd=10.
  - When both MEM and WB match, MEM takes priority.
- hazard ⇒ stall_if=stall_id=bubble_ex=1.
- flush_id = jump & ~stall_id & ~freeze. If a jump arrives during a stall, it is ignored that cycle and re-evaluated once the operands are valid.
- FSM:
  - RUN→WAIT when mem_req & ~mem_ready.
  - WAIT→RUN on mem_ready.
  - Any cycle with mem_req & ~mem_ready asserts freeze, stall_if and stall_id. The scoreboard holds and bubble_ex=0.
  - Freeze has priority over hazard, and no bubble is inserted while frozen.

## Timing
- All outputs combinational from scoreboard/state and same-cycle ID inputs; zero-cycle decision.
- Scoreboard/state update one edge after the decision.
- Load-use, dependent in next slot: 2 stall cycles (EX match, then MEM-load match); forwarded from WB on 3rd.
- ALU-use, next slot: 1 stall cycle, then fwd=01.
- Reset (async assert, any state including WAIT): state=RUN, all entries invalid. Outputs then stall_if=stall_id=bubble_ex=freeze=flush_id=0, fwd_*_sel=00.
- Release is synchronous to clk.

## Configuration
- HAZARD_FORWARD_EN defined: forwarding as above.
- Undefined:
  - fwd_*_sel tied to 00.
  - Stall on any EX or MEM match.
  - WB match needs no stall, because the register file writes through.

## Structure
- Shared package mips_pkg:
  - FWD_REGFILE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - The hazard FSM state enum (RUN, WAIT).
  - The scoreboard-entry struct/width constant.
- One natural sub-module: hazard_scoreboard, holding the three-entry shift register with advance/bubble/hold controls and per-source match vectors. The top level holds the FSM and priority logic.

## Test plan
- lw $2 in ID, then add $3,$2,$4 → stall/bubble 2 cycles, then fwd_s_sel=10, no further stall.
- add $5,$1,$1; then beq $5,$0 → 1-cycle stall, then fwd_s_sel=01, flush_id only on the beq's non-stalled cycle with jump=1.
- Destination $0 write followed by a reader of $0 → no stall, fwd=00.
- mem_req=1, mem_ready=0 for 3 cycles with a load-use pending → freeze=1 for 3 cycles, bubble_ex=0, scoreboard unchanged; load-use stalls resume afterwards.
- rst_n pulsed low mid-WAIT → all outputs 0 immediately, state RUN, an older pending $2 write no longer causes a stall.
- HAZARD_FORWARD_EN undefined: add $3,$2 after add $2 → 2-cycle stall, fwd always 00.
